// File: rtl/router_pkg.sv
// Shared router definitions: FIFO geometry, header length field and the stored entry layout.
package router_pkg;

    localparam int DATA_W     = 8;
    localparam int FIFO_DEPTH = 16;
    localparam int FIFO_AW    = 4;
    localparam int PLEN_MSB   = 7;
    localparam int PLEN_LSB   = 2;

    typedef struct packed {
        logic              tag;
        logic [DATA_W-1:0] data;
    } fifo_entry_t;

    // Bytes still to come after a header: payload length plus the parity byte.
    function automatic logic [6:0] pkt_len_from_header(input logic [DATA_W-1:0] hdr);
        return {1'b0, hdr[PLEN_MSB:PLEN_LSB]} + 7'd1;
    endfunction

endpackage

// File: rtl/router_fifo_if.sv
// Write/read handshake and status bundle between one router output FIFO and its neighbours.
// FIFO_ERR_EN adds sticky overflow/underflow status signals.
interface router_fifo_if
    import router_pkg::*;
#(
    parameter int WIDTH = DATA_W
);
    logic             write_enb;
    logic             lfd_state;
    logic [WIDTH-1:0] data_in;
    logic             read_enb;
    logic [WIDTH-1:0] data_out;
    logic             empty;
    logic             full;
`ifdef FIFO_ERR_EN
    logic             overflow;
    logic             underflow;

    modport slave (
        input  write_enb, lfd_state, data_in, read_enb,
        output data_out, empty, full, overflow, underflow
    );
    modport master (
        output write_enb, lfd_state, data_in, read_enb,
        input  data_out, empty, full, overflow, underflow
    );
`else
    modport slave (
        input  write_enb, lfd_state, data_in, read_enb,
        output data_out, empty, full
    );
    modport master (
        output write_enb, lfd_state, data_in, read_enb,
        input  data_out, empty, full
    );
`endif
endinterface

// File: rtl/router_fifo_mem.sv
// Simple dual-port FIFO storage: synchronous write, combinational read.
// Only the header tag bits are cleared; data bits are don't-care until written.
module router_fifo_mem #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16,
    parameter int AW    = 4
) (
    input  logic           clock,
    input  logic           clr,
    input  logic           we,
    input  logic [AW-1:0]  waddr,
    input  logic [WIDTH:0] wdata,
    input  logic [AW-1:0]  raddr,
    output logic [WIDTH:0] rdata
);

    logic [WIDTH-1:0] data_mem [DEPTH];
    logic [DEPTH-1:0] tag_r;

    // Data byte array write port.
    always_ff @(posedge clock) begin
        if (we) begin
            data_mem[waddr] <= wdata[WIDTH-1:0];
        end
    end

    // Header tag array, flushed by reset and soft reset.
    always_ff @(posedge clock) begin
        if (clr) begin
            tag_r <= '0;
        end else if (we) begin
            tag_r[waddr] <= wdata[WIDTH];
        end
    end

    assign rdata = {tag_r[raddr], data_mem[raddr]};

endmodule

// File: rtl/router_fifo.sv
// One output FIFO of the 1x3 router: pointers, flags, packet-length tracking and idle output.
// Optional FIFO_ERR_EN adds sticky overflow/underflow flags on the interface.
module router_fifo
    import router_pkg::*;
#(
    parameter int WIDTH = DATA_W,
    parameter int DEPTH = FIFO_DEPTH,
    parameter int AW    = FIFO_AW
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          soft_reset,
    router_fifo_if.slave  bus
);

    localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic [6:0]       pkt_count;
    logic [WIDTH-1:0] data_q;

    logic             clr_s;
    logic             empty_s;
    logic             full_s;
    logic             wr_acc_s;
    logic             rd_acc_s;
    logic             mem_we_s;
    fifo_entry_t      wr_entry_s;
    fifo_entry_t      rd_entry_s;

    assign clr_s    = reset | soft_reset;
    assign empty_s  = (wr_ptr == rd_ptr);
    assign full_s   = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign wr_acc_s = bus.write_enb & ~full_s;
    assign rd_acc_s = bus.read_enb & ~empty_s;
    assign mem_we_s = wr_acc_s & ~clr_s;

    assign wr_entry_s.tag  = bus.lfd_state;
    assign wr_entry_s.data = bus.data_in;

    router_fifo_mem #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_mem (
        .clock (clock),
        .clr   (clr_s),
        .we    (mem_we_s),
        .waddr (wr_ptr[AW-1:0]),
        .wdata (wr_entry_s),
        .raddr (rd_ptr[AW-1:0]),
        .rdata (rd_entry_s)
    );

    // Read/write pointer advance; a flush overrides any concurrent access.
    always_ff @(posedge clock) begin
        if (clr_s) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (wr_acc_s) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (rd_acc_s) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
        end
    end

    // Registered read data and remaining-packet count; output idles at zero between packets.
    always_ff @(posedge clock) begin
        if (clr_s) begin
            data_q    <= '0;
            pkt_count <= 7'd0;
        end else if (rd_acc_s) begin
            data_q <= rd_entry_s.data;
            if (rd_entry_s.tag) begin
                pkt_count <= pkt_len_from_header(rd_entry_s.data);
            end else if (pkt_count != 7'd0) begin
                pkt_count <= pkt_count - 7'd1;
            end
        end else if (pkt_count == 7'd0) begin
            data_q <= '0;
        end
    end

`ifdef FIFO_ERR_EN
    logic overflow_r;
    logic underflow_r;

    // Sticky error flags; a write that coincides with a read is not an overflow.
    always_ff @(posedge clock) begin
        if (clr_s) begin
            overflow_r  <= 1'b0;
            underflow_r <= 1'b0;
        end else begin
            if (bus.write_enb && full_s && !bus.read_enb) begin
                overflow_r <= 1'b1;
            end
            if (bus.read_enb && empty_s) begin
                underflow_r <= 1'b1;
            end
        end
    end

    assign bus.overflow  = overflow_r;
    assign bus.underflow = underflow_r;
`else
`endif

    assign bus.data_out = data_q;
    assign bus.empty    = empty_s;
    assign bus.full     = full_s;

endmodule

// File: tb/tb_router_fifo.sv
// Self-checking bench for router_fifo: directed scenarios then random traffic against a queue model.
module tb_router_fifo;

    logic clock = 1'b0;
    logic reset;
    logic soft_reset;

    router_fifo_if #(.WIDTH(8)) bus ();

    router_fifo dut (
        .clock      (clock),
        .reset      (reset),
        .soft_reset (soft_reset),
        .bus        (bus)
    );

    always #5 clock = ~clock;

    int         n_checks = 0;
    int         n_fail   = 0;
    logic [8:0] q[$];
    int         remaining = 0;
    logic [7:0] exp_dout  = 8'h00;
    bit         exp_ovf   = 1'b0;
    bit         exp_unf   = 1'b0;
    bit         saw_ff    = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock: drive inputs, advance the model, sample #1 after the edge and compare.
    task automatic step(input logic wr, input logic lfd, input logic [7:0] din,
                        input logic rd, input logic sr, input logic rs);
        logic [8:0] ent;
        bit         do_rd;
        bit         do_wr;
        bus.write_enb = wr;
        bus.lfd_state = lfd;
        bus.data_in   = din;
        bus.read_enb  = rd;
        soft_reset    = sr;
        reset         = rs;
        if (rs || sr) begin
            q.delete();
            remaining = 0;
            exp_dout  = 8'h00;
            exp_ovf   = 1'b0;
            exp_unf   = 1'b0;
        end else begin
            do_rd = rd && (q.size() > 0);
            do_wr = wr && (q.size() < 16);
            if (wr && q.size() == 16 && !rd) exp_ovf = 1'b1;
            if (rd && q.size() == 0) exp_unf = 1'b1;
            if (do_rd) begin
                ent      = q.pop_front();
                exp_dout = ent[7:0];
                if (ent[8]) remaining = int'(ent[7:2]) + 1;
                else if (remaining > 0) remaining--;
            end else if (remaining == 0) begin
                exp_dout = 8'h00;
            end
            if (do_wr) q.push_back({lfd, din});
        end
        @(posedge clock);
        #1;
        chk("empty", bus.empty, q.size() == 0);
        chk("full", bus.full, q.size() == 16);
        chk("data_out", bus.data_out, exp_dout);
`ifdef FIFO_ERR_EN
        chk("overflow", bus.overflow, exp_ovf);
        chk("underflow", bus.underflow, exp_unf);
`endif
        if (bus.data_out === 8'hFF) saw_ff = 1'b1;
    endtask

    task automatic wr_byte(input logic lfd, input logic [7:0] din);
        step(1'b1, lfd, din, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic rd_byte();
        step(1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    endtask

    task automatic idle();
        step(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        logic [7:0] pkt_exp [6];
        logic [7:0] exp_b;
        pkt_exp[0] = 8'h0C; pkt_exp[1] = 8'h11; pkt_exp[2] = 8'h22;
        pkt_exp[3] = 8'h33; pkt_exp[4] = 8'hAA; pkt_exp[5] = 8'h00;

        // Reset and idle.
        step(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
        chk("rst_empty", bus.empty, 1'b1);
        chk("rst_full", bus.full, 1'b0);
        for (int i = 0; i < 5; i++) begin
            idle();
            chk("idle_dout", bus.data_out, 8'h00);
        end

        // Single packet: header length 3, three payload bytes, parity.
        wr_byte(1'b1, 8'h0C);
        wr_byte(1'b0, 8'h11);
        wr_byte(1'b0, 8'h22);
        wr_byte(1'b0, 8'h33);
        wr_byte(1'b0, 8'hAA);
        for (int i = 0; i < 5; i++) begin
            rd_byte();
            chk("pkt_seq", bus.data_out, pkt_exp[i]);
        end
        chk("pkt_empty", bus.empty, 1'b1);
        idle();
        chk("pkt_seq", bus.data_out, pkt_exp[5]);

        // Fill to full, dropped 17th write, drain.
        for (int i = 0; i < 16; i++) wr_byte(1'b0, 8'h40 + 8'(i));
        chk("full16", bus.full, 1'b1);
        wr_byte(1'b0, 8'hFF);
        chk("full17", bus.full, 1'b1);
`ifdef FIFO_ERR_EN
        chk("ovf_set", bus.overflow, 1'b1);
`endif
        saw_ff = 1'b0;
        for (int i = 0; i < 16; i++) begin
            rd_byte();
            chk("drain_seq", bus.data_out, 8'h40 + 8'(i));
        end
        chk("no_ff", saw_ff, 1'b0);
        chk("drain_empty", bus.empty, 1'b1);

        // Full with simultaneous read and write.
        step(1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 16; i++) wr_byte(1'b0, 8'h80 + 8'(i));
        step(1'b1, 1'b0, 8'hEE, 1'b1, 1'b0, 1'b0);
        chk("rw_full_dout", bus.data_out, 8'h80);
        chk("rw_full_flag", bus.full, 1'b0);
        chk("rw_full_empty", bus.empty, 1'b0);
        for (int k = 0; k < 4; k++) begin
            step(1'b1, 1'b0, 8'hC0 + 8'(k), 1'b1, 1'b0, 1'b0);
            chk("rw_dout", bus.data_out, 8'h81 + 8'(k));
            chk("rw_full", bus.full, 1'b0);
        end
        for (int i = 0; i < 15; i++) begin
            rd_byte();
            exp_b = (i < 11) ? 8'h85 + 8'(i) : 8'hC0 + 8'(i - 11);
            chk("rw_order", bus.data_out, exp_b);
        end
        chk("rw_empty", bus.empty, 1'b1);

        // Soft reset flush with concurrent write.
        for (int i = 0; i < 6; i++) wr_byte(1'b0, 8'h50 + 8'(i));
        step(1'b1, 1'b0, 8'h77, 1'b0, 1'b1, 1'b0);
        chk("srst_empty", bus.empty, 1'b1);
        chk("srst_dout", bus.data_out, 8'h00);
        rd_byte();
        chk("srst_rd_empty", bus.empty, 1'b1);
        chk("srst_rd_dout", bus.data_out, 8'h00);

        // Pointer wrap: three rounds of ten in, ten out.
        for (int r = 0; r < 3; r++) begin
            for (int i = 0; i < 10; i++) wr_byte(1'b0, 8'(r * 16 + i + 1));
            for (int i = 0; i < 10; i++) begin
                rd_byte();
                chk("wrap_data", bus.data_out, 8'(r * 16 + i + 1));
            end
            chk("wrap_empty", bus.empty, 1'b1);
        end

        // Random traffic against the model.
        for (int n = 0; n < 800; n++) begin
            step(1'($urandom_range(0, 99) < 60), 1'($urandom_range(0, 9) == 0),
                 8'($urandom), 1'($urandom_range(0, 99) < 55),
                 1'($urandom_range(0, 199) == 0), 1'b0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
